// File: rtl/rasterizer_pkg.sv
// Shared types for the triangle rasterizer: FSM state encoding, edge accumulator type
// and default screen geometry.
package rasterizer_pkg;

    localparam int DEF_COORD_WIDTH = 16;
    localparam int DEF_SCREEN_W    = 320;
    localparam int DEF_SCREEN_H    = 240;
    localparam int EDGE_WIDTH      = 2 * DEF_COORD_WIDTH + 2;

    typedef logic signed [EDGE_WIDTH-1:0] edge_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP0,
        ST_SETUP1,
        ST_SCAN,
        ST_FINISH
    } rast_state_t;

endpackage

// File: rtl/edge_stepper.sv
// One incremental edge function: a row-start and a current accumulator, stepped by the
// per-edge x/y increments latched at setup. inside is the sign of the current value.
module edge_stepper
    import rasterizer_pkg::*;
#(
    parameter int W = $bits(edge_t)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic signed [W-1:0] i_init,
    input  logic signed [W-1:0] i_step_x,
    input  logic signed [W-1:0] i_step_y,
    input  logic                i_x_en,
    input  logic                i_row_en,
    output logic                o_inside
);

    logic signed [W-1:0] r_sx;
    logic signed [W-1:0] r_sy;
    logic signed [W-1:0] r_row;
    logic signed [W-1:0] r_cur;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sx  <= '0;
            r_sy  <= '0;
            r_row <= '0;
            r_cur <= '0;
        end else if (i_load) begin
            r_sx  <= i_step_x;
            r_sy  <= i_step_y;
            r_row <= i_init;
            r_cur <= i_init;
        end else if (i_row_en) begin
            r_row <= r_row + r_sy;
            r_cur <= r_row + r_sy;
        end else if (i_x_en) begin
            r_cur <= r_cur + r_sx;
        end
    end

    assign o_inside = !r_cur[W-1];

endmodule

// File: rtl/tri_rasterizer.sv
// Triangle rasterizer: clipped-bbox scan with incremental edge functions and depth
// interpolation, streaming covered pixels over a valid/ready handshake.
//   state  | meaning
//   IDLE   | waiting for start, ready_out=1
//   SETUP0 | deltas, area, clipped bbox
//   SETUP1 | edge/depth values at bbox top-left, cull decision
//   SCAN   | one bbox pixel per cycle, frozen while a drawn pixel is stalled
//   FINISH | done pulse (culled qualifies it)
module tri_rasterizer
    import rasterizer_pkg::*;
#(
    parameter int COORD_WIDTH     = DEF_COORD_WIDTH,
    parameter int DEPTH_BIT_WIDTH = 16,
    parameter int FRAC_BITS       = 8,
    parameter int SCREEN_W        = DEF_SCREEN_W,
    parameter int SCREEN_H        = DEF_SCREEN_H
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic                                        start,
    output logic                                        ready_out,
    input  logic signed [COORD_WIDTH-1:0]               x0,
    input  logic signed [COORD_WIDTH-1:0]               y0,
    input  logic signed [COORD_WIDTH-1:0]               x1,
    input  logic signed [COORD_WIDTH-1:0]               y1,
    input  logic signed [COORD_WIDTH-1:0]               x2,
    input  logic signed [COORD_WIDTH-1:0]               y2,
    input  logic signed [DEPTH_BIT_WIDTH+FRAC_BITS-1:0] z0,
    input  logic signed [DEPTH_BIT_WIDTH+FRAC_BITS-1:0] dzdx,
    input  logic signed [DEPTH_BIT_WIDTH+FRAC_BITS-1:0] dzdy,
    output logic [$clog2(SCREEN_W)-1:0]                 x,
    output logic [$clog2(SCREEN_H)-1:0]                 y,
    output logic [DEPTH_BIT_WIDTH-1:0]                  z,
    output logic                                        drawing,
    input  logic                                        pixel_ready,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        culled
);

    localparam int CW  = COORD_WIDTH;
    localparam int DW  = CW + 1;
    localparam int EW  = 2 * CW + 2;
    localparam int ZIN = DEPTH_BIT_WIDTH + FRAC_BITS;
    localparam int ZW  = ZIN + CW + 2;
    localparam int XW  = $clog2(SCREEN_W);
    localparam int YW  = $clog2(SCREEN_H);
    localparam logic signed [CW-1:0] X_LIM  = CW'(SCREEN_W - 1);
    localparam logic signed [CW-1:0] Y_LIM  = CW'(SCREEN_H - 1);
    localparam logic [XW-1:0]        X_LAST = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0]        Y_LAST = YW'(SCREEN_H - 1);

    rast_state_t r_state, w_state_next;

    logic signed [CW-1:0]  r_vx [3];
    logic signed [CW-1:0]  r_vy [3];
    logic signed [ZIN-1:0] r_z0, r_dzdx, r_dzdy;
    logic signed [DW-1:0]  r_dx [3];
    logic signed [DW-1:0]  r_dy [3];
    logic [XW-1:0]         r_bx_lo, r_bx_hi, r_px;
    logic [YW-1:0]         r_by_lo, r_by_hi, r_py;
    logic                  r_cull, r_culled;
    logic signed [ZW-1:0]  r_zrow, r_zacc;

    logic signed [DW-1:0]  w_dx [3];
    logic signed [DW-1:0]  w_dy [3];
    logic signed [EW-1:0]  w_init [3];
    logic [2:0]            w_inside;
    logic signed [EW-1:0]  w_area;
    logic signed [CW-1:0]  w_xmin, w_xmax, w_ymin, w_ymax;
    logic                  w_bbox_empty;
    logic signed [DW-1:0]  w_px0, w_py0;
    logic signed [ZW-1:0]  w_zinit, w_zint;
    logic                  w_accept, w_load, w_x_en, w_row_en, w_stall;

    for (genvar i = 0; i < 3; i++) begin : g_edge
        localparam int B = (i + 1) % 3;
        assign w_dx[i] = DW'(r_vx[B]) - DW'(r_vx[i]);
        assign w_dy[i] = DW'(r_vy[B]) - DW'(r_vy[i]);
        assign w_init[i] = EW'(r_dx[i]) * EW'(w_py0 - DW'(r_vy[i]))
                         - EW'(r_dy[i]) * EW'(w_px0 - DW'(r_vx[i]));

        edge_stepper #(.W(EW)) u_edge (
            .i_clk    (clk_in),
            .i_rst    (rst_in),
            .i_load   (w_load),
            .i_init   (w_init[i]),
            .i_step_x (-EW'(r_dy[i])),
            .i_step_y (EW'(r_dx[i])),
            .i_x_en   (w_x_en),
            .i_row_en (w_row_en),
            .o_inside (w_inside[i])
        );
    end

    // E0(v2) rewritten with the v2->v0 deltas so no extra subtractors are needed
    assign w_area = EW'(w_dy[0]) * EW'(w_dx[2]) - EW'(w_dx[0]) * EW'(w_dy[2]);

    always_comb begin
        w_xmin = r_vx[0];
        w_xmax = r_vx[0];
        w_ymin = r_vy[0];
        w_ymax = r_vy[0];
        for (int i = 1; i < 3; i++) begin
            if (r_vx[i] < w_xmin) w_xmin = r_vx[i];
            if (r_vx[i] > w_xmax) w_xmax = r_vx[i];
            if (r_vy[i] < w_ymin) w_ymin = r_vy[i];
            if (r_vy[i] > w_ymax) w_ymax = r_vy[i];
        end
    end

    assign w_bbox_empty = w_xmax[CW-1] || (w_xmin > X_LIM) || w_ymax[CW-1] || (w_ymin > Y_LIM);

    assign w_px0   = DW'($signed({1'b0, r_bx_lo}));
    assign w_py0   = DW'($signed({1'b0, r_by_lo}));
    assign w_zinit = ZW'(r_z0)
                   + ZW'(r_dzdx) * ZW'(w_px0 - DW'(r_vx[0]))
                   + ZW'(r_dzdy) * ZW'(w_py0 - DW'(r_vy[0]));

    assign drawing = (r_state == ST_SCAN) && (&w_inside);
    assign w_stall = drawing && !pixel_ready;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_x_en       = 1'b0;
        w_row_en     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SETUP0;
                end
            end
            ST_SETUP0: w_state_next = ST_SETUP1;
            ST_SETUP1: begin
                if (r_cull) begin
                    w_state_next = ST_FINISH;
                end else begin
                    w_load       = 1'b1;
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!w_stall) begin
                    if (r_px != r_bx_hi)      w_x_en       = 1'b1;
                    else if (r_py != r_by_hi) w_row_en     = 1'b1;
                    else                      w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 3; i++) begin
                r_vx[i] <= '0;
                r_vy[i] <= '0;
                r_dx[i] <= '0;
                r_dy[i] <= '0;
            end
            r_z0     <= '0;
            r_dzdx   <= '0;
            r_dzdy   <= '0;
            r_bx_lo  <= '0;
            r_bx_hi  <= '0;
            r_by_lo  <= '0;
            r_by_hi  <= '0;
            r_px     <= '0;
            r_py     <= '0;
            r_cull   <= 1'b0;
            r_culled <= 1'b0;
            r_zrow   <= '0;
            r_zacc   <= '0;
        end else begin
            if (w_accept) begin
                r_vx[0] <= x0;
                r_vy[0] <= y0;
                r_vx[1] <= x1;
                r_vy[1] <= y1;
                r_vx[2] <= x2;
                r_vy[2] <= y2;
                r_z0    <= z0;
                r_dzdx  <= dzdx;
                r_dzdy  <= dzdy;
            end
            if (r_state == ST_SETUP0) begin
                for (int i = 0; i < 3; i++) begin
                    r_dx[i] <= w_dx[i];
                    r_dy[i] <= w_dy[i];
                end
                r_bx_lo <= w_xmin[CW-1] ? '0 : w_xmin[XW-1:0];
                r_by_lo <= w_ymin[CW-1] ? '0 : w_ymin[YW-1:0];
                r_bx_hi <= (w_xmax > X_LIM) ? X_LAST : w_xmax[XW-1:0];
                r_by_hi <= (w_ymax > Y_LIM) ? Y_LAST : w_ymax[YW-1:0];
                r_cull  <= w_area[EW-1] || (w_area == '0) || w_bbox_empty;
            end
            if (r_state == ST_SETUP1) r_culled <= r_cull;
            if (w_load) begin
                r_px   <= r_bx_lo;
                r_py   <= r_by_lo;
                r_zrow <= w_zinit;
                r_zacc <= w_zinit;
            end
            if (w_x_en) begin
                r_px   <= r_px + XW'(1);
                r_zacc <= r_zacc + ZW'(r_dzdx);
            end
            if (w_row_en) begin
                r_px   <= r_bx_lo;
                r_py   <= r_py + YW'(1);
                r_zrow <= r_zrow + ZW'(r_dzdy);
                r_zacc <= r_zrow + ZW'(r_dzdy);
            end
        end
    end

    assign w_zint = r_zacc >>> FRAC_BITS;
    assign z = w_zint[ZW-1]                       ? '0 :
               (|w_zint[ZW-2:DEPTH_BIT_WIDTH])    ? '1 :
               w_zint[DEPTH_BIT_WIDTH-1:0];

    assign x         = r_px;
    assign y         = r_py;
    assign busy      = (r_state == ST_SETUP0) || (r_state == ST_SETUP1) || (r_state == ST_SCAN);
    assign ready_out = (r_state == ST_IDLE);
    assign done      = (r_state == ST_FINISH);
    assign culled    = (r_state == ST_FINISH) && r_culled;

endmodule

// File: tb/tb_tri_rasterizer.sv
// Self-checking bench for tri_rasterizer: directed vector table, reset-abort sequence and
// random triangles compared against a direct per-pixel edge/depth model.
module tb_tri_rasterizer;

    localparam int CW  = 16;
    localparam int DB  = 16;
    localparam int FB  = 8;
    localparam int SW  = 320;
    localparam int SH  = 240;
    localparam int ZIN = DB + FB;

    logic clk_in = 1'b0;
    logic rst_in, start, pixel_ready;
    logic signed [CW-1:0]  x0, y0, x1, y1, x2, y2;
    logic signed [ZIN-1:0] z0, dzdx, dzdy;
    logic ready_out, drawing, busy, done, culled;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [15:0] z;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int x0, y0, x1, y1, x2, y2;
        int z0, dzdx, dzdy;
        int toggle;
        int exp_count, exp_lat, exp_culled;
        int probe_x, probe_y, probe_z;
    } vec_t;

    typedef struct {
        int x, y, z;
    } pix_t;

    pix_t exp_q[$];
    pix_t got_q[$];

    tri_rasterizer dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .ready_out(ready_out),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .z0(z0), .dzdx(dzdx), .dzdy(dzdy),
        .x(x), .y(y), .z(z), .drawing(drawing), .pixel_ready(pixel_ready),
        .busy(busy), .done(done), .culled(culled)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic longint edge_fn(int xa, int ya, int xb, int yb, int px, int py);
        return longint'(xb - xa) * longint'(py - ya) - longint'(yb - ya) * longint'(px - xa);
    endfunction

    // Reference: visit the clipped bbox directly and evaluate coverage and depth per pixel.
    task automatic build_model(input vec_t v, output int lat, output int cul);
        longint area, zacc, zi;
        int xl, xh, yl, yh;
        exp_q.delete();
        area = edge_fn(v.x0, v.y0, v.x1, v.y1, v.x2, v.y2);
        xl = v.x0; xh = v.x0; yl = v.y0; yh = v.y0;
        if (v.x1 < xl) xl = v.x1;
        if (v.x2 < xl) xl = v.x2;
        if (v.x1 > xh) xh = v.x1;
        if (v.x2 > xh) xh = v.x2;
        if (v.y1 < yl) yl = v.y1;
        if (v.y2 < yl) yl = v.y2;
        if (v.y1 > yh) yh = v.y1;
        if (v.y2 > yh) yh = v.y2;
        if (xl < 0) xl = 0;
        if (yl < 0) yl = 0;
        if (xh > SW - 1) xh = SW - 1;
        if (yh > SH - 1) yh = SH - 1;
        if (area <= 0 || xl > xh || yl > yh) begin
            cul = 1;
            lat = 3;
            return;
        end
        cul = 0;
        lat = 3 + (xh - xl + 1) * (yh - yl + 1);
        for (int py = yl; py <= yh; py++) begin
            for (int px = xl; px <= xh; px++) begin
                if (edge_fn(v.x0, v.y0, v.x1, v.y1, px, py) >= 0 &&
                    edge_fn(v.x1, v.y1, v.x2, v.y2, px, py) >= 0 &&
                    edge_fn(v.x2, v.y2, v.x0, v.y0, px, py) >= 0) begin
                    zacc = longint'(v.z0) + longint'(v.dzdx) * (px - v.x0)
                         + longint'(v.dzdy) * (py - v.y0);
                    zi = zacc >>> FB;
                    if (zi < 0) zi = 0;
                    if (zi > 65535) zi = 65535;
                    exp_q.push_back('{px, py, int'(zi)});
                end
            end
        end
    endtask

    task automatic run_tri(input vec_t v, input string tag, output int lat, output int cul_seen);
        int   held;
        int   stall_bad;
        pix_t hold_p;
        got_q.delete();
        lat = -1;
        cul_seen = 0;
        held = 0;
        stall_bad = 0;
        for (int k = 0; k < 40 && !ready_out; k++) @(negedge clk_in);
        check($sformatf("%s ready_before_start", tag), ready_out, 1);
        x0 = 16'(v.x0); y0 = 16'(v.y0);
        x1 = 16'(v.x1); y1 = 16'(v.y1);
        x2 = 16'(v.x2); y2 = 16'(v.y2);
        z0 = 24'(v.z0); dzdx = 24'(v.dzdx); dzdy = 24'(v.dzdy);
        start = 1'b1;
        pixel_ready = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        check($sformatf("%s busy_T+1", tag), busy, 1);
        for (int cyc = 1; cyc < 20000; cyc++) begin
            if (held != 0) begin
                if (!drawing || x != 9'(hold_p.x) || y != 8'(hold_p.y) || z != 16'(hold_p.z))
                    stall_bad++;
            end
            if (done) begin
                lat = cyc;
                cul_seen = culled;
                check($sformatf("%s busy_at_done", tag), busy, 0);
                break;
            end
            pixel_ready = (v.toggle != 0) ? cyc[0] : 1'b1;
            held = 0;
            if (drawing) begin
                if (pixel_ready) begin
                    got_q.push_back('{int'(x), int'(y), int'(z)});
                end else begin
                    held = 1;
                    hold_p = '{int'(x), int'(y), int'(z)};
                end
            end
            @(negedge clk_in);
        end
        pixel_ready = 1'b1;
        check($sformatf("%s done_seen", tag), (lat >= 0) ? 1 : 0, 1);
        check($sformatf("%s stall_hold_violations", tag), stall_bad, 0);
        @(negedge clk_in);
        check($sformatf("%s ready_after_done", tag), ready_out, 1);
    endtask

    task automatic compare_pixels(input string tag);
        check($sformatf("%s pixel_count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y || got_q[i].z != exp_q[i].z) begin
                n_fail++;
                $display("FAIL %s pixel[%0d]: got (%0d,%0d,z=%0d), expected (%0d,%0d,z=%0d)", tag, i,
                         got_q[i].x, got_q[i].y, got_q[i].z, exp_q[i].x, exp_q[i].y, exp_q[i].z);
            end
        end
    endtask

    initial begin
        vec_t vt[10];
        int   elat, ecul, glat, gcul, pz;

        //          x0   y0   x1   y1   x2   y2   z0       dzdx     dzdy     tog cnt lat  cul px py pz
        vt[0] = '{  0,   0,   4,   0,   0,   4,   0,       0,       0,       0,  15, 28,  0,  2, 1, 0};
        vt[1] = '{  0,   0,   0,   4,   4,   0,   0,       0,       0,       0,  0,  3,   1, -1,-1, 0};
        vt[2] = '{-10, -10,  20, -10, -10,  20,   256000,  -763,    1792,    0,  66, 444, 0,  0, 0, 1040};
        vt[3] = '{  0,   0,   4,   0,   0,   4,   0,       0,       0,       1,  15, -1,  0, -1,-1, 0};
        vt[4] = '{  0,   0,   4,   0,   0,   4,   25600,   256,     512,     0,  15, 28,  0,  2, 1, 104};
        vt[5] = '{  0,   0,   4,   0,   0,   4,   -1280,   0,       0,       0,  15, 28,  0,  3, 1, 0};
        vt[6] = '{  0,   0,   4,   0,   0,   4,   7680000, 5120000, 5120000, 0,  15, 28,  0,  4, 0, 65535};
        vt[7] = '{400,  10, 420,  10, 400,  30,   0,       0,       0,       0,  0,  3,   1, -1,-1, 0};
        vt[8] = '{310, 230, 330, 230, 310, 250,   0,       0,       0,       0,  100, 103, 0, -1,-1, 0};
        vt[9] = '{  0,   0,   2,   2,   4,   4,   0,       0,       0,       0,  0,  3,   1, -1,-1, 0};

        rst_in = 1'b1;
        start = 1'b0;
        pixel_ready = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        z0 = '0; dzdx = '0; dzdy = '0;
        repeat (3) @(negedge clk_in);
        check("reset ready_out", ready_out, 1);
        check("reset x", x, 0);
        check("reset y", y, 0);
        check("reset z", z, 0);
        check("reset drawing", drawing, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset culled", culled, 0);
        rst_in = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            build_model(vt[i], elat, ecul);
            run_tri(vt[i], tag, glat, gcul);
            compare_pixels(tag);
            check($sformatf("%s table_count", tag), got_q.size(), vt[i].exp_count);
            check($sformatf("%s culled", tag), gcul, vt[i].exp_culled);
            if (vt[i].exp_lat >= 0) check($sformatf("%s done_latency", tag), glat, vt[i].exp_lat);
            if (vt[i].probe_x >= 0) begin
                pz = -1;
                foreach (got_q[k])
                    if (got_q[k].x == vt[i].probe_x && got_q[k].y == vt[i].probe_y) pz = got_q[k].z;
                check($sformatf("%s probe_z(%0d,%0d)", tag, vt[i].probe_x, vt[i].probe_y), pz, vt[i].probe_z);
            end
        end

        // abort a scan with reset, then the same triangle must reproduce cleanly
        build_model(vt[0], elat, ecul);
        x0 = 16'(0); y0 = 16'(0); x1 = 16'(4); y1 = 16'(0); x2 = 16'(0); y2 = 16'(4);
        z0 = '0; dzdx = '0; dzdy = '0;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (6) @(negedge clk_in);
        check("midscan drawing_before_reset", drawing, 1);
        rst_in = 1'b1;
        #1;
        check("midscan drawing_in_reset", drawing, 0);
        check("midscan busy_in_reset", busy, 0);
        check("midscan ready_in_reset", ready_out, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            check("midscan no_done", done, 0);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        run_tri(vt[0], "after_reset", glat, gcul);
        compare_pixels("after_reset");
        check("after_reset done_latency", glat, elat);
        check("after_reset culled", gcul, ecul);

        for (int r = 0; r < 14; r++) begin
            vec_t  v;
            int    bx, by;
            string tag;
            tag = $sformatf("rand%0d", r);
            bx = ($urandom_range(0, 3) == 0) ? 290 : -8;
            by = ($urandom_range(0, 3) == 0) ? 205 : -8;
            v.x0 = bx + int'($urandom_range(0, 40));
            v.y0 = by + int'($urandom_range(0, 40));
            v.x1 = bx + int'($urandom_range(0, 40));
            v.y1 = by + int'($urandom_range(0, 40));
            v.x2 = bx + int'($urandom_range(0, 40));
            v.y2 = by + int'($urandom_range(0, 40));
            v.z0 = (int'($urandom_range(0, 32000)) - 2000) * 256 + int'($urandom_range(0, 255));
            v.dzdx = int'($urandom_range(0, 600000)) - 300000;
            v.dzdy = int'($urandom_range(0, 600000)) - 300000;
            v.toggle = int'($urandom_range(0, 1));
            v.exp_count = 0; v.exp_lat = 0; v.exp_culled = 0;
            v.probe_x = -1; v.probe_y = -1; v.probe_z = 0;
            build_model(v, elat, ecul);
            run_tri(v, tag, glat, gcul);
            compare_pixels(tag);
            check($sformatf("%s culled", tag), gcul, ecul);
            if (v.toggle == 0) check($sformatf("%s done_latency", tag), glat, elat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
